exec_ctrl_fsm: RTL and testbench

- Parametrised multi-cycle execute/memory/writeback controller for the RV32-class core.
- Sits between the decoder/register file and the ALU, data memory and PC.
- Accepts one decoded instruction per handshake, then sequences the ALU result, memory access or branch resolution, and the register-file write.
- Adds over the previous controller: a valid/ready instruction interface, a memory req/ready handshake with wait states, load sign/zero extension, store byte enables, signed/unsigned branch compare, and misalignment traps.

---
 rtl/exec_ctrl_pkg.sv | 65 ++++++
 rtl/exec_ctrl_fsm_lsu_align.sv | 65 ++++++
 rtl/exec_ctrl_fsm.sv | 256 +++++++++++++++++++++++++
 tb/tb_exec_ctrl_fsm.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared types and constants for the execute/memory/writeback controller.
// Holds the op class and state enums, trap causes and funct3 encodings.
package exec_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_ALU    = 4'd0,
        OP_LUI    = 4'd1,
        OP_AUIPC  = 4'd2,
        OP_JAL    = 4'd3,
        OP_JALR   = 4'd4,
        OP_BRANCH = 4'd5,
        OP_LOAD   = 4'd6,
        OP_STORE  = 4'd7
    } op_class_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    localparam logic [1:0] TRAP_LOAD_MISALIGN  = 2'd0;
    localparam logic [1:0] TRAP_STORE_MISALIGN = 2'd1;
    localparam logic [1:0] TRAP_ILLEGAL        = 2'd2;
    localparam logic [1:0] TRAP_MEM_TIMEOUT    = 2'd3;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;
    localparam logic [2:0] F3_SD  = 3'd3;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    // Doubleword accesses and LWU only exist on a 64-bit datapath.
    function automatic logic funct3Legal(input logic [3:0] opClass,
                                         input logic [2:0] f3,
                                         input logic       is64);
        logic ok;
        ok = 1'b0;
        case (opClass)
            OP_ALU, OP_LUI, OP_AUIPC, OP_JAL: ok = 1'b1;
            OP_JALR:   ok = (f3 == 3'd0);
            OP_BRANCH: ok = (f3 != 3'd2) && (f3 != 3'd3);
            OP_LOAD:   ok = (f3 != 3'd7) && (is64 || ((f3 != F3_LD) && (f3 != F3_LWU)));
            OP_STORE:  ok = (f3 <= F3_SD) && (is64 || (f3 != F3_SD));
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/exec_ctrl_fsm_lsu_align.sv
// Combinational load/store lane logic: store replication and byte enables,
// load lane extraction with sign/zero extension, and misalignment detection.
module lsu_align
    import exec_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        addr_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN/8-1:0] be_o,
    output logic [XLEN-1:0]   load_o,
    output logic              misalign_o
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = (XLEN == 64) ? 3 : 2;

    logic [OFFW-1:0] offset;
    logic [XLEN-1:0] shifted;

    assign offset = addr_i[OFFW-1:0];

    // The low funct3 bits encode access size for both loads and stores.
    always_comb begin
        wdata_o    = '0;
        be_o       = '0;
        misalign_o = 1'b0;
        shifted    = rdata_i >> {offset, 3'b000};
        case (funct3_i[1:0])
            2'd0: begin
                for (int i = 0; i < NB; i++) wdata_o[8*i +: 8] = rs2_i[7:0];
                be_o = NB'(1) << offset;
            end
            2'd1: begin
                for (int i = 0; i < NB; i++) wdata_o[8*i +: 8] = rs2_i[8*(i%2) +: 8];
                be_o       = NB'(3) << offset;
                misalign_o = addr_i[0];
            end
            2'd2: begin
                for (int i = 0; i < NB; i++) wdata_o[8*i +: 8] = rs2_i[8*(i%4) +: 8];
                be_o       = NB'(4'hF) << offset;
                misalign_o = |addr_i[1:0];
            end
            default: begin
                wdata_o    = rs2_i;
                be_o       = '1;
                misalign_o = |addr_i[2:0];
            end
        endcase

        case (funct3_i)
            F3_LB:   load_o = XLEN'($signed(shifted[7:0]));
            F3_LH:   load_o = XLEN'($signed(shifted[15:0]));
            F3_LW:   load_o = XLEN'($signed(shifted[31:0]));
            F3_LBU:  load_o = XLEN'(shifted[7:0]);
            F3_LHU:  load_o = XLEN'(shifted[15:0]);
            F3_LWU:  load_o = XLEN'(shifted[31:0]);
            default: load_o = shifted;
        endcase
    end

endmodule

// File: rtl/exec_ctrl_fsm.sv
// Multi-cycle execute/memory/writeback controller (IDLE/EXEC/MEM/WB).
// Optional memory wait timeout trap: define EXEC_CTRL_MEM_TIMEOUT_EN.
module exec_ctrl_fsm
    import exec_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PC_STEP     = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [3:0]        op_class_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   rs1_val_i,
    input  logic [XLEN-1:0]   rs2_val_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   alu_result_i,
    output logic              alu_en_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_be_o,
    input  logic              mem_ready_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              rf_we_o,
    output logic [XLEN-1:0]   rf_wdata_o,
    output logic              jump_valid_o,
    output logic [XLEN-1:0]   jump_target_o,
    output logic              trap_o,
    output logic [1:0]        trap_cause_o
);

    state_e            state_q;
    logic [3:0]        opClass_q;
    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   rs1_q, rs2_q, imm_q, pc_q;

    logic              instrReady_q, aluEn_q, memReq_q, memWe_q, rfWe_q;
    logic              jumpValid_q, trap_q;
    logic [1:0]        trapCause_q;
    logic [XLEN-1:0]   memAddr_q, memWdata_q, rfWdata_q, jumpTarget_q;
    logic [XLEN/8-1:0] memBe_q;

`ifdef EXEC_CTRL_MEM_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYC + 1);
    logic [CNTW-1:0]   memCnt_q;
`else
    logic              unusedTimeoutParam;
    assign unusedTimeoutParam = (TIMEOUT_CYC > 0);
`endif

    logic              isIdle, legal, branchTaken, lsuMisalign;
    logic [2:0]        selF3;
    logic [XLEN-1:0]   selRs1, selRs2, selImm, lsuAddr, jalrTarget;
    logic [XLEN-1:0]   lsuWdata, lsuLoad;
    logic [XLEN/8-1:0] lsuBe;

    // In IDLE the lane logic looks at the incoming instruction so misalign
    // traps can be decided at accept; afterwards it uses the latched copy.
    assign isIdle     = (state_q == ST_IDLE);
    assign selRs1     = isIdle ? rs1_val_i : rs1_q;
    assign selRs2     = isIdle ? rs2_val_i : rs2_q;
    assign selImm     = isIdle ? imm_i     : imm_q;
    assign selF3      = isIdle ? funct3_i  : funct3_q;
    assign lsuAddr    = selRs1 + selImm;
    assign jalrTarget = (rs1_val_i + imm_i) & ~XLEN'(1);
    assign legal      = funct3Legal(op_class_i, funct3_i, XLEN == 64);

    always_comb begin
        branchTaken = 1'b0;
        case (funct3_i)
            F3_BEQ:  branchTaken = (rs1_val_i == rs2_val_i);
            F3_BNE:  branchTaken = (rs1_val_i != rs2_val_i);
            F3_BLT:  branchTaken = ($signed(rs1_val_i) <  $signed(rs2_val_i));
            F3_BGE:  branchTaken = ($signed(rs1_val_i) >= $signed(rs2_val_i));
            F3_BLTU: branchTaken = (rs1_val_i <  rs2_val_i);
            F3_BGEU: branchTaken = (rs1_val_i >= rs2_val_i);
            default: branchTaken = 1'b0;
        endcase
    end

    lsu_align #(.XLEN(XLEN)) u_lsu_align (
        .addr_i     (lsuAddr[2:0]),
        .funct3_i   (selF3),
        .rs2_i      (selRs2),
        .rdata_i    (mem_rdata_i),
        .wdata_o    (lsuWdata),
        .be_o       (lsuBe),
        .load_o     (lsuLoad),
        .misalign_o (lsuMisalign)
    );

    // EXEC-cycle pulses (alu_en, jump_valid, trap) are registered at the
    // accept edge so they are visible during the EXEC cycle itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            opClass_q    <= '0;
            funct3_q     <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            instrReady_q <= 1'b1;
            aluEn_q      <= 1'b0;
            memReq_q     <= 1'b0;
            memWe_q      <= 1'b0;
            memAddr_q    <= '0;
            memWdata_q   <= '0;
            memBe_q      <= '0;
            rfWe_q       <= 1'b0;
            rfWdata_q    <= '0;
            jumpValid_q  <= 1'b0;
            jumpTarget_q <= '0;
            trap_q       <= 1'b0;
            trapCause_q  <= '0;
`ifdef EXEC_CTRL_MEM_TIMEOUT_EN
            memCnt_q     <= '0;
`endif
        end else begin
            aluEn_q     <= 1'b0;
            rfWe_q      <= 1'b0;
            jumpValid_q <= 1'b0;
            trap_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid_i) begin
                        opClass_q    <= op_class_i;
                        funct3_q     <= funct3_i;
                        rs1_q        <= rs1_val_i;
                        rs2_q        <= rs2_val_i;
                        imm_q        <= imm_i;
                        pc_q         <= pc_i;
                        instrReady_q <= 1'b0;
                        state_q      <= ST_EXEC;
                        if (!legal) begin
                            trap_q      <= 1'b1;
                            trapCause_q <= TRAP_ILLEGAL;
                        end else begin
                            case (op_class_i)
                                OP_ALU, OP_LUI, OP_AUIPC: aluEn_q <= 1'b1;
                                OP_JAL: begin
                                    jumpValid_q  <= 1'b1;
                                    jumpTarget_q <= pc_i + imm_i;
                                end
                                OP_JALR: begin
                                    jumpValid_q  <= 1'b1;
                                    jumpTarget_q <= jalrTarget;
                                end
                                OP_BRANCH: begin
                                    if (branchTaken) begin
                                        jumpValid_q  <= 1'b1;
                                        jumpTarget_q <= pc_i + imm_i;
                                    end
                                end
                                OP_LOAD, OP_STORE: begin
                                    if (lsuMisalign) begin
                                        trap_q      <= 1'b1;
                                        trapCause_q <= (op_class_i == OP_LOAD) ?
                                                       TRAP_LOAD_MISALIGN : TRAP_STORE_MISALIGN;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_EXEC: begin
                    if (trap_q || opClass_q == OP_BRANCH) begin
                        instrReady_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else begin
                        case (opClass_q)
                            OP_ALU, OP_LUI, OP_AUIPC: begin
                                rfWdata_q <= alu_result_i;
                                rfWe_q    <= 1'b1;
                                state_q   <= ST_WB;
                            end
                            OP_JAL, OP_JALR: begin
                                rfWdata_q <= pc_q + XLEN'(PC_STEP);
                                rfWe_q    <= 1'b1;
                                state_q   <= ST_WB;
                            end
                            OP_LOAD, OP_STORE: begin
                                memReq_q   <= 1'b1;
                                memWe_q    <= (opClass_q == OP_STORE);
                                memAddr_q  <= lsuAddr;
                                memWdata_q <= lsuWdata;
                                memBe_q    <= lsuBe;
`ifdef EXEC_CTRL_MEM_TIMEOUT_EN
                                memCnt_q   <= '0;
`endif
                                state_q    <= ST_MEM;
                            end
                            default: begin
                                instrReady_q <= 1'b1;
                                state_q      <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_MEM: begin
                    if (mem_ready_i) begin
                        memReq_q <= 1'b0;
                        if (memWe_q) begin
                            instrReady_q <= 1'b1;
                            state_q      <= ST_IDLE;
                        end else begin
                            rfWdata_q <= lsuLoad;
                            rfWe_q    <= 1'b1;
                            state_q   <= ST_WB;
                        end
                    end
`ifdef EXEC_CTRL_MEM_TIMEOUT_EN
                    else if (memCnt_q == CNTW'(TIMEOUT_CYC - 1)) begin
                        memReq_q     <= 1'b0;
                        trap_q       <= 1'b1;
                        trapCause_q  <= TRAP_MEM_TIMEOUT;
                        instrReady_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else begin
                        memCnt_q <= memCnt_q + 1'b1;
                    end
`endif
                end
                ST_WB: begin
                    instrReady_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    instrReady_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr_ready_o = instrReady_q;
    assign alu_en_o      = aluEn_q;
    assign mem_req_o     = memReq_q;
    assign mem_we_o      = memWe_q;
    assign mem_addr_o    = memAddr_q;
    assign mem_wdata_o   = memWdata_q;
    assign mem_be_o      = memBe_q;
    assign rf_we_o       = rfWe_q;
    assign rf_wdata_o    = rfWdata_q;
    assign jump_valid_o  = jumpValid_q;
    assign jump_target_o = jumpTarget_q;
    assign trap_o        = trap_q;
    assign trap_cause_o  = trapCause_q;

endmodule

// File: tb/tb_exec_ctrl_fsm.sv
// Directed bench for exec_ctrl_fsm: ALU, loads, stores, branches, jumps,
// traps, memory wait states and reset during a memory access.
module tb_exec_ctrl_fsm;
    import exec_ctrl_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            instr_valid, instr_ready;
    logic [3:0]      op_class;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val, rs2_val, imm, pc, alu_result;
    logic            alu_en, mem_req, mem_we, mem_ready;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]      mem_be;
    logic            rf_we, jump_valid, trap;
    logic [XLEN-1:0] rf_wdata, jump_target;
    logic [1:0]      trap_cause;

    int errorCount = 0;
    int checkCount = 0;
    int n;

    always #5 clk = ~clk;

    exec_ctrl_fsm #(.XLEN(XLEN), .PC_STEP(4), .TIMEOUT_CYC(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid_i (instr_valid),
        .instr_ready_o (instr_ready),
        .op_class_i    (op_class),
        .funct3_i      (funct3),
        .rs1_val_i     (rs1_val),
        .rs2_val_i     (rs2_val),
        .imm_i         (imm),
        .pc_i          (pc),
        .alu_result_i  (alu_result),
        .alu_en_o      (alu_en),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_be_o      (mem_be),
        .mem_ready_i   (mem_ready),
        .mem_rdata_i   (mem_rdata),
        .rf_we_o       (rf_we),
        .rf_wdata_o    (rf_wdata),
        .jump_valid_o  (jump_valid),
        .jump_target_o (jump_target),
        .trap_o        (trap),
        .trap_cause_o  (trap_cause)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Presents one instruction for a single accept cycle; returns in EXEC.
    task automatic applyStimulus(input logic [3:0] op, input logic [2:0] f3,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] immVal, input logic [31:0] pcVal);
        op_class    = op;
        funct3      = f3;
        rs1_val     = rs1;
        rs2_val     = rs2;
        imm         = immVal;
        pc          = pcVal;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic waitMem(input int readyDelay, output int reqCycles);
        reqCycles = 0;
        for (int c = 0; c <= readyDelay; c++) begin
            if (c == readyDelay) mem_ready = 1'b1;
            if (mem_req) reqCycles++;
            tick();
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; op_class = '0; funct3 = '0;
        rs1_val = '0; rs2_val = '0; imm = '0; pc = '0; alu_result = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        tick(); tick();
        checkOutput("rst instr_ready", 64'(instr_ready), 64'(1));
        checkOutput("rst mem_req",     64'(mem_req),     64'(0));
        checkOutput("rst rf_we",       64'(rf_we),       64'(0));
        checkOutput("rst trap",        64'(trap),        64'(0));
        checkOutput("rst jump_valid",  64'(jump_valid),  64'(0));
        checkOutput("rst alu_en",      64'(alu_en),      64'(0));
        rst = 1'b0;
        tick();

        // ADD: rf_we two cycles after accept, ready again on the third
        alu_result = 32'h0000_0007;
        applyStimulus(OP_ALU, 3'd0, 32'd5, 32'd2, 32'd0, 32'd0);
        checkOutput("add alu_en",      64'(alu_en),      64'(1));
        checkOutput("add busy",        64'(instr_ready), 64'(0));
        tick();
        checkOutput("add rf_we",       64'(rf_we),       64'(1));
        checkOutput("add rf_wdata",    64'(rf_wdata),    64'(32'h7));
        tick();
        checkOutput("add ready",       64'(instr_ready), 64'(1));
        checkOutput("add rf_we low",   64'(rf_we),       64'(0));
        checkOutput("add wdata hold",  64'(rf_wdata),    64'(32'h7));

        // LB / LBU at 0x1001 with three wait states
        mem_rdata = 32'h0000_8000;
        applyStimulus(OP_LOAD, F3_LB, 32'h1000, 32'd0, 32'd1, 32'd0);
        checkOutput("lb no trap",      64'(trap),        64'(0));
        tick();
        checkOutput("lb mem_addr",     64'(mem_addr),    64'(32'h1001));
        checkOutput("lb mem_be",       64'(mem_be),      64'(4'b0010));
        checkOutput("lb mem_we",       64'(mem_we),      64'(0));
        waitMem(3, n);
        checkOutput("lb req cycles",   64'(n),           64'(4));
        checkOutput("lb rf_we",        64'(rf_we),       64'(1));
        checkOutput("lb rf_wdata",     64'(rf_wdata),    64'(32'hFFFF_FF80));
        checkOutput("lb req dropped",  64'(mem_req),     64'(0));
        tick();
        applyStimulus(OP_LOAD, F3_LBU, 32'h1000, 32'd0, 32'd1, 32'd0);
        tick();
        waitMem(3, n);
        checkOutput("lbu req cycles",  64'(n),           64'(4));
        checkOutput("lbu rf_wdata",    64'(rf_wdata),    64'(32'h0000_0080));
        tick();

        // SH at 0x102
        applyStimulus(OP_STORE, F3_SH, 32'h100, 32'h1234_ABCD, 32'd2, 32'd0);
        tick();
        checkOutput("sh mem_req",      64'(mem_req),     64'(1));
        checkOutput("sh mem_we",       64'(mem_we),      64'(1));
        checkOutput("sh mem_be",       64'(mem_be),      64'(4'b1100));
        checkOutput("sh mem_wdata",    64'(mem_wdata),   64'(32'hABCD_ABCD));
        checkOutput("sh mem_addr",     64'(mem_addr),    64'(32'h102));
        waitMem(0, n);
        checkOutput("sh req dropped",  64'(mem_req),     64'(0));
        checkOutput("sh ready",        64'(instr_ready), 64'(1));
        checkOutput("sh no rf_we",     64'(rf_we),       64'(0));

        // BLT taken (signed), BLTU not taken with same operands
        applyStimulus(OP_BRANCH, F3_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h400);
        checkOutput("blt jump_valid",  64'(jump_valid),  64'(1));
        checkOutput("blt target",      64'(jump_target), 64'(32'h420));
        checkOutput("blt no trap",     64'(trap),        64'(0));
        tick();
        checkOutput("blt pulse end",   64'(jump_valid),  64'(0));
        checkOutput("blt ready",       64'(instr_ready), 64'(1));
        applyStimulus(OP_BRANCH, F3_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h400);
        checkOutput("bltu no jump",    64'(jump_valid),  64'(0));
        tick();
        checkOutput("bltu ready",      64'(instr_ready), 64'(1));

        // Misaligned LW and SW trap without touching memory
        applyStimulus(OP_LOAD, F3_LW, 32'h1000, 32'd0, 32'd2, 32'd0);
        checkOutput("lw trap",         64'(trap),        64'(1));
        checkOutput("lw cause",        64'(trap_cause),  64'(TRAP_LOAD_MISALIGN));
        checkOutput("lw no req",       64'(mem_req),     64'(0));
        tick();
        checkOutput("lw trap pulse",   64'(trap),        64'(0));
        checkOutput("lw still no req", 64'(mem_req),     64'(0));
        applyStimulus(OP_STORE, F3_SW, 32'h100, 32'd0, 32'd1, 32'd0);
        checkOutput("sw trap cause",   64'({trap, trap_cause}), 64'({1'b1, TRAP_STORE_MISALIGN}));
        tick();

        // JALR to 0x2001 clears bit 0, links pc+4
        applyStimulus(OP_JALR, 3'd0, 32'h2000, 32'd0, 32'd1, 32'h300);
        checkOutput("jalr jump_valid", 64'(jump_valid),  64'(1));
        checkOutput("jalr target",     64'(jump_target), 64'(32'h2000));
        tick();
        checkOutput("jalr rf_we",      64'(rf_we),       64'(1));
        checkOutput("jalr link",       64'(rf_wdata),    64'(32'h304));
        checkOutput("jalr pulse end",  64'(jump_valid),  64'(0));
        tick();

        // Unknown op class
        applyStimulus(4'd9, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        checkOutput("illegal trap",    64'({trap, trap_cause}), 64'({1'b1, TRAP_ILLEGAL}));
        checkOutput("illegal no jump", 64'(jump_valid),  64'(0));
        tick();

        // Memory that never answers
        mem_rdata = 32'hCAFE_0001;
        applyStimulus(OP_LOAD, F3_LW, 32'h1000, 32'd0, 32'd0, 32'd0);
        tick();
`ifdef EXEC_CTRL_MEM_TIMEOUT_EN
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            tick();
        end
        checkOutput("timeout cycles",  64'(n),           64'(15));
        checkOutput("timeout trap",    64'({trap, trap_cause}), 64'({1'b1, TRAP_MEM_TIMEOUT}));
        tick();
`else
        repeat (20) tick();
        checkOutput("wait req held",   64'(mem_req),     64'(1));
        checkOutput("wait no trap",    64'(trap),        64'(0));
        waitMem(0, n);
        checkOutput("wait lw data",    64'(rf_wdata),    64'(32'hCAFE_0001));
        tick();
`endif

        // Asynchronous reset in the middle of a store
        applyStimulus(OP_STORE, F3_SW, 32'h1000, 32'h55, 32'd0, 32'd0);
        tick();
        checkOutput("pre-rst mem_req", 64'(mem_req),     64'(1));
        rst = 1'b1;
        #1;
        checkOutput("rst mid mem_req", 64'(mem_req),     64'(0));
        checkOutput("rst mid ready",   64'(instr_ready), 64'(1));
        checkOutput("rst mid mem_be",  64'(mem_be),      64'(0));
        checkOutput("rst mid rfdata",  64'(rf_wdata),    64'(0));
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post-rst ready",  64'(instr_ready), 64'(1));
        checkOutput("post-rst req",    64'(mem_req),     64'(0));

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
